alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DWIDTH, 32, operand/result width.
REQ-002 Parameter: NREQ, 2, number of requester ports (fixed at 2 this revision).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset_N  input  1  reset, asynchronous and active-low.
REQ-005 Req_Valid  input  [NREQ]  requester i presents an operation.
REQ-006 Req_Ready  output  [NREQ]  requester i operation accepted this cycle.
REQ-007 Req_A, Req_B  input  [NREQ][DWIDTH]  operands per requester.
REQ-008 Req_OP  input  [NREQ][4]  ALU opcode per requester, same encoding as the shared ALU.
REQ-009 Rsp_Valid  output  [NREQ]  result available for requester i.
REQ-010 Rsp_Ready  input  [NREQ]  requester i consumes result.
REQ-011 Rsp_Result  output  DWIDTH  registered ALU result, shared bus, qualified by Rsp_Valid.
REQ-012 Rsp_Zero  output  1  registered ALU zero flag, qualified by Rsp_Valid.

Function
REQ-013 Block SHALL time-share one ALU instance between requesters; FSM states IDLE, HOLD.
REQ-014 Accept condition: state IDLE, or state HOLD with Rsp_Valid[owner] && Rsp_Ready[owner] in same cycle.
REQ-015 On accept with any Req_Valid set, grant exactly one requester round-robin: priority starts at index after Last_Grant; Req_Ready[grant] high that cycle only.
REQ-016 Granted Req_A/B/OP SHALL drive the ALU combinationally; ALU_Out, zero flag, and owner index registered on the accept edge.
REQ-017 Latency: accept in cycle N -> Rsp_Valid[owner] high from cycle N+1; exactly one Rsp_Valid bit high at a time.
REQ-018 Rsp_Result/Rsp_Zero/owner SHALL stay stable while Rsp_Valid high and Rsp_Ready[owner] low.
REQ-019 Transitions: IDLE->HOLD on grant; HOLD->HOLD on response handshake plus new grant (back-to-back, 1 op/cycle); HOLD->IDLE on handshake with no Req_Valid; HOLD->HOLD otherwise.
REQ-020 Req_Ready all-zero in HOLD without owner handshake (backpressure); Rsp_Ready on non-owner ports ignored.
REQ-021 Last_Grant updates only on grant; simultaneous requests alternate 0,1,0,1.
REQ-022 Opcodes 4'b1010-4'b1111 SHALL be accepted normally; result 0, Rsp_Zero 1.
REQ-023 Result width DWIDTH, add/sub wrap modulo 2^DWIDTH, no overflow flag.
REQ-024 Requester may drop Req_Valid before grant; no operation issued, no state change.

Reset
REQ-025 Reset_N low SHALL immediately force: state IDLE, Req_Ready 0, Rsp_Valid 0, Rsp_Result 0, Rsp_Zero 0, owner 0, Last_Grant = NREQ-1 (port 0 wins first).
REQ-026 Reset mid-HOLD SHALL discard the pending result; no Rsp_Valid after deassertion until a new grant.
REQ-027 First grant possible on first rising edge after Reset_N deasserts.

Structure
REQ-028 Shared package SHALL hold ALU opcode constants (ADD..AND, 4'b0000-4'b1001), FSM state enum, DWIDTH default.
REQ-029 One sub-module: alu (DWIDTH passed through), single instance; arbitration, FSM, result register in alu_arbiter.

Verification
REQ-030 Single: port 0 A=5, B=3, OP=ADD -> Req_Ready[0] cycle N; Rsp_Valid[0], Result=8, Zero=0 cycle N+1.
REQ-031 Contention: both valid continuously, Rsp_Ready=11 -> grants 0,1,0,1; one result per cycle; port 0 SUB 7-7 -> Result 0, Zero 1.
REQ-032 Backpressure: port 1 XOR FFFF0000^0000FFFF, Rsp_Ready[1]=0 for 4 cycles -> Result FFFFFFFF held stable, Req_Ready 00 throughout; release -> next grant same cycle.
REQ-033 Reset mid-HOLD: Reset_N low while Rsp_Valid[0] high -> outputs zero immediately; after release no Rsp_Valid until new Req_Valid.
REQ-034 Illegal op: OP=4'b1111, A=1, B=1 -> accepted, Result 0, Zero 1.
REQ-035 Random: 1000 mixed ops both ports, random ready/valid -> scoreboard per port, every result matches model, none lost or duplicated.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcode map, FSM states, default width.
package alu_arbiter_pkg;

  localparam int unsigned DWIDTH_DEFAULT = 32;

  // ALU opcodes; 4'b1010..4'b1111 are unassigned and produce a zero result.
  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpSll  = 4'b0010;
  localparam logic [3:0] OpSrl  = 4'b0011;
  localparam logic [3:0] OpSra  = 4'b0100;
  localparam logic [3:0] OpSlt  = 4'b0101;
  localparam logic [3:0] OpSltu = 4'b0110;
  localparam logic [3:0] OpXor  = 4'b0111;
  localparam logic [3:0] OpOr   = 4'b1000;
  localparam logic [3:0] OpAnd  = 4'b1001;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU shared by all requesters of the arbiter.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEFAULT
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic [3:0]        op,
  output logic [DWIDTH-1:0] result,
  output logic              zero
);

  localparam int unsigned ShW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  logic [ShW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = b[ShW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  // Opcode decode; add/sub wrap naturally at DWIDTH bits.
  always_comb begin
    result = '0;
    case (op)
      OpAdd:   result = a + b;
      OpSub:   result = a - b;
      OpSll:   result = a << shamt;
      OpSrl:   result = a >> shamt;
      OpSra:   result = $unsigned($signed(a) >>> shamt);
      OpSlt:   result = {{(DWIDTH-1){1'b0}}, lt_s};
      OpSltu:  result = {{(DWIDTH-1){1'b0}}, lt_u};
      OpXor:   result = a ^ b;
      OpOr:    result = a | b;
      OpAnd:   result = a & b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter time-sharing one ALU between NREQ requesters, one
// registered result held until its owner consumes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEFAULT,
  parameter int unsigned NREQ   = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][DWIDTH-1:0] req_a,
  input  logic [NREQ-1:0][DWIDTH-1:0] req_b,
  input  logic [NREQ-1:0][3:0]        req_op,
  output logic [NREQ-1:0]             rsp_valid,
  input  logic [NREQ-1:0]             rsp_ready,
  output logic [DWIDTH-1:0]           rsp_result,
  output logic                        rsp_zero
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   owner_q;
  logic [IdxW-1:0]   last_grant_q;
  logic [DWIDTH-1:0] result_q;
  logic              zero_q;

  logic              handshake;
  logic              accept;
  logic              grant_valid;
  logic [IdxW-1:0]   grant_idx;
  int unsigned       rr_idx;

  logic [DWIDTH-1:0] alu_result;
  logic              alu_zero;

  assign handshake   = (state_q == StHold) && rsp_ready[owner_q];
  assign accept      = (state_q == StIdle) || handshake;
  assign grant_valid = accept && (|req_valid);

  // Round-robin pick: search starts at the port after the last grant.
  always_comb begin
    grant_idx = '0;
    rr_idx    = 0;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      rr_idx = (32'(last_grant_q) + i) % NREQ;
      if (req_valid[rr_idx]) begin
        grant_idx = IdxW'(rr_idx);
      end
    end
  end

  alu_arbiter_alu #(
    .DWIDTH(DWIDTH)
  ) u_alu (
    .a     (req_a[grant_idx]),
    .b     (req_b[grant_idx]),
    .op    (req_op[grant_idx]),
    .result(alu_result),
    .zero  (alu_zero)
  );

  // Next-state: stay in HOLD while the owner stalls, drop to IDLE when drained.
  always_comb begin
    state_d = state_q;
    if (grant_valid) begin
      state_d = StHold;
    end else if (accept) begin
      state_d = StIdle;
    end
  end

  // Outputs: ready pulses for the grantee, valid flags the owner while held.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    // Ready is gated by reset so it drops the moment reset asserts.
    if (grant_valid && reset_n) begin
      req_ready[grant_idx] = 1'b1;
    end
    if (state_q == StHold) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Result, owner and round-robin pointer capture on every grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q      <= '0;
      last_grant_q <= IdxW'(NREQ - 1);
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else if (grant_valid) begin
      owner_q      <= grant_idx;
      last_grant_q <= grant_idx;
      result_q     <= alu_result;
      zero_q       <= alu_zero;
    end
  end

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model with per-port scoreboards.
module tb_alu_arbiter;

  localparam int DW = 32;

  logic             clk;
  logic             reset_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][3:0]  req_op;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero;

  alu_arbiter #(
    .DWIDTH(DW),
    .NREQ  (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_zero  (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: whether a result is outstanding, for whom, and its value.
  bit          m_busy;
  int          m_owner;
  int          m_last;
  logic [31:0] m_res;
  logic        m_zero;
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  logic [1:0]  obs_ready;
  logic [1:0]  obs_valid;
  logic [31:0] obs_result;
  logic        obs_zero;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << sh;
      4'd3:    return a >> sh;
      4'd4:    return $unsigned($signed(a) >>> sh);
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a ^ b;
      4'd8:    return a | b;
      4'd9:    return a & b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
    req_a[p]  = a;
    req_b[p]  = b;
    req_op[p] = op;
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model.
  task automatic tick();
    bit          hs;
    bit          acc;
    int          g;
    int          p;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_valid;
    logic [31:0] nres;
    logic [32:0] entry;
    @(negedge clk);
    obs_ready  = req_ready;
    obs_valid  = rsp_valid;
    obs_result = rsp_result;
    obs_zero   = rsp_zero;
    hs  = m_busy && rsp_ready[m_owner];
    acc = !m_busy || hs;
    g   = -1;
    if (acc) begin
      for (int k = 1; k <= 2; k++) begin
        p = (m_last + k) % 2;
        if (g < 0 && req_valid[p]) g = p;
      end
    end
    exp_ready = 2'b00;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_valid = 2'b00;
    if (m_busy) exp_valid[m_owner] = 1'b1;
    check("req_ready", obs_ready, exp_ready);
    check("rsp_valid", obs_valid, exp_valid);
    if (m_busy) begin
      check("rsp_result", obs_result, m_res);
      check("rsp_zero", obs_zero, m_zero);
    end
    for (int k = 0; k < 2; k++) begin
      if (obs_valid[k] && rsp_ready[k]) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          check("sb_unexpected_rsp", 64'(k + 1), 64'd0);
        end else begin
          entry = (k == 0) ? q0.pop_front() : q1.pop_front();
          check(k == 0 ? "sb_port0" : "sb_port1", {obs_zero, obs_result}, entry);
        end
      end
    end
    nres = (g >= 0) ? ref_alu(req_op[g], req_a[g], req_b[g]) : 32'd0;
    @(posedge clk);
    if (g >= 0) begin
      m_busy  = 1'b1;
      m_owner = g;
      m_last  = g;
      m_res   = nres;
      m_zero  = (nres == 32'd0);
      if (g == 0) q0.push_back({m_zero, nres});
      else        q1.push_back({m_zero, nres});
    end else if (acc) begin
      m_busy = 1'b0;
    end
    #1;
  endtask

  // Assert reset mid-cycle, confirm outputs clear at once, release after an edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_zero", rsp_zero, 1'b0);
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = 1;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [1:0] exp_seq[4];

  initial begin
    reset_n   = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    #2;
    do_reset();

    // Single ADD on port 0.
    set_port(0, 32'd5, 32'd3, 4'd0);
    req_valid = 2'b01;
    tick();
    check("single_ready", obs_ready, 2'b01);
    req_valid = 2'b00;
    tick();
    check("single_valid", obs_valid, 2'b01);
    check("single_result", obs_result, 32'd8);
    check("single_zero", obs_zero, 1'b0);
    tick();
    check("single_idle", obs_valid, 2'b00);

    // Contention: alternating grants, one result per cycle.
    do_reset();
    set_port(0, 32'd7, 32'd7, 4'd1);
    set_port(1, 32'd1, 32'd2, 4'd0);
    req_valid  = 2'b11;
    exp_seq[0] = 2'b01;
    exp_seq[1] = 2'b10;
    exp_seq[2] = 2'b01;
    exp_seq[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("contend_grant", obs_ready, exp_seq[i]);
      if (i > 0) begin
        check("contend_valid", obs_valid, exp_seq[i-1]);
        check("contend_result", obs_result, (i % 2 == 1) ? 32'd0 : 32'd3);
        check("contend_zero", obs_zero, (i % 2 == 1) ? 1'b1 : 1'b0);
      end
    end
    req_valid = 2'b00;
    tick();
    tick();

    // Backpressure on port 1 holds the result and blocks all grants.
    do_reset();
    set_port(1, 32'hFFFF_0000, 32'h0000_FFFF, 4'd7);
    set_port(0, 32'd1, 32'd1, 4'd0);
    rsp_ready = 2'b00;
    req_valid = 2'b10;
    tick();
    check("bp_grant1", obs_ready, 2'b10);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_ready_low", obs_ready, 2'b00);
      check("bp_valid", obs_valid, 2'b10);
      check("bp_result", obs_result, 32'hFFFF_FFFF);
    end
    rsp_ready = 2'b10;
    tick();
    check("bp_release_grant", obs_ready, 2'b01);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    tick();
    check("bp_next_valid", obs_valid, 2'b01);
    check("bp_next_result", obs_result, 32'd2);
    tick();

    // Reset while a result is held for port 0.
    set_port(0, 32'd5, 32'd3, 4'd0);
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    check("mid_hold_valid", obs_valid, 2'b01);
    req_valid = 2'b01;
    do_reset();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_quiet", obs_valid, 2'b00);
    end

    // Unassigned opcode is accepted and yields zero.
    set_port(0, 32'd1, 32'd1, 4'hF);
    req_valid = 2'b01;
    tick();
    check("illegal_ready", obs_ready, 2'b01);
    req_valid = 2'b00;
    tick();
    check("illegal_valid", obs_valid, 2'b01);
    check("illegal_result", obs_result, 32'd0);
    check("illegal_zero", obs_zero, 1'b1);
    tick();

    // Random mixed traffic.
    for (int i = 0; i < 1000; i++) begin
      for (int p = 0; p < 2; p++) begin
        case ($urandom_range(0, 3))
          0: set_port(p, 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)));
          1: begin
            req_a[p]  = $urandom;
            req_b[p]  = req_a[p];
            req_op[p] = 4'($urandom_range(0, 15));
          end
          default: set_port(p, $urandom, $urandom, 4'($urandom_range(0, 15)));
        endcase
      end
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    tick();
    tick();
    tick();
    check("sb_drained0", 64'(q0.size()), 64'd0);
    check("sb_drained1", 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
